// File: rtl/fip_32_dot3_seq.sv
// -----------------------------------------------------------------------------
// fip_32_dot3_seq
//   Sequential Q16.16 3-vector dot product (a.b) for ray/triangle math.
//   One shared signed WIDTHxWIDTH multiplier is reused over three cycles, one
//   cycle for each of the x, y and z products. The products are summed in a
//   wide accumulator, and only the final sum is clamped to a signed Q16.16
//   value.
//
//   State table
//     state  | meaning
//     -------+-----------------------------------------------------------
//     S_IDLE | in_ready=1; waiting for in_valid, latches the 6 operands
//     S_ACC  | adds one shifted product per edge (idx 0,1,2 = x,y,z)
//     S_SAT  | clamps the accumulator into result/overflow, raises out_valid
//     S_DONE | holds result until out_ready, then returns to S_IDLE
//
// Ports
//   clk                 single clock; all state changes on the rising edge
//   reset               synchronous, active-high
//   a_x,a_y,a_z         vector A, signed Q16.16
//   b_x,b_y,b_z         vector B, signed Q16.16
//   in_valid/in_ready   input handshake (in_ready == state is S_IDLE)
//   result              saturated dot product, signed Q16.16
//   overflow            result was clamped; meaningful while out_valid
//   out_valid/out_ready output handshake
// -----------------------------------------------------------------------------
module fip_32_dot3_seq #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16,
  parameter int ACC_W     = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] a_x,
  input  logic signed [WIDTH-1:0] a_y,
  input  logic signed [WIDTH-1:0] a_z,
  input  logic signed [WIDTH-1:0] b_x,
  input  logic signed [WIDTH-1:0] b_y,
  input  logic signed [WIDTH-1:0] b_z,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Width of a product after the arithmetic shift drops the fraction bits.
  localparam int PW = 2*WIDTH - FRAC_BITS;

  // Clamp limits, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_SAT  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                  state_q;
  logic [1:0]              idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [WIDTH-1:0] ax_q, ay_q, az_q;
  logic signed [WIDTH-1:0] bx_q, by_q, bz_q;
  logic signed [WIDTH-1:0] res_q;
  logic                    ovf_q;
  logic                    ovalid_q;

  // Operand select for the shared multiplier.
  logic signed [WIDTH-1:0]   mul_a, mul_b;
  logic signed [2*WIDTH-1:0] prod_full;
  logic signed [PW-1:0]      prod_shr;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_d;
  logic [FRAC_BITS-1:0]      unused_prod_lsbs;

  logic signed [WIDTH-1:0] sat_res_d;
  logic                    sat_ovf_d;

  always_comb begin
    mul_a = az_q;
    mul_b = bz_q;
    case (idx_q)
      2'd0:    begin mul_a = ax_q; mul_b = bx_q; end
      2'd1:    begin mul_a = ay_q; mul_b = by_q; end
      default: begin mul_a = az_q; mul_b = bz_q; end
    endcase
  end

  // Full-precision signed product. Dropping the low FRAC_BITS is an
  // arithmetic shift right, so the result is rounded toward -inf.
  assign prod_full        = mul_a * mul_b;
  assign prod_shr         = prod_full[2*WIDTH-1:FRAC_BITS];
  assign unused_prod_lsbs = prod_full[FRAC_BITS-1:0];
  assign prod_ext         = {{(ACC_W-PW){prod_shr[PW-1]}}, prod_shr};
  assign acc_d            = acc_q + prod_ext;

  // Only the final sum is clamped. Intermediate partial sums may go beyond
  // the 32-bit range and still cancel out exactly.
  always_comb begin
    sat_res_d = acc_q[WIDTH-1:0];
    sat_ovf_d = 1'b0;
    if (acc_q > ACC_MAX) begin
      sat_res_d = {1'b0, {(WIDTH-1){1'b1}}};
      sat_ovf_d = 1'b1;
    end else if (acc_q < ACC_MIN) begin
      sat_res_d = {1'b1, {(WIDTH-1){1'b0}}};
      sat_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      acc_q    <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      az_q     <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      bz_q     <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            ax_q    <= a_x;
            ay_q    <= a_y;
            az_q    <= a_z;
            bx_q    <= b_x;
            by_q    <= b_y;
            bz_q    <= b_z;
            acc_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd2) begin
            state_q <= S_SAT;
          end
        end
        S_SAT: begin
          res_q    <= sat_res_d;
          ovf_q    <= sat_ovf_d;
          ovalid_q <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          // out_valid is high throughout S_DONE, so out_ready alone completes
          // the handshake. in_ready rises only in the next cycle.
          if (out_ready) begin
            ovalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign out_valid = ovalid_q;

endmodule

// File: tb/tb_fip_32_dot3_seq.sv
module tb_fip_32_dot3_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_x, a_y, a_z, b_x, b_y, b_z;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fip_32_dot3_seq dut (
    .clk       (clk),
    .reset     (reset),
    .a_x       (a_x),
    .a_y       (a_y),
    .a_z       (a_z),
    .b_x       (b_x),
    .b_y       (b_y),
    .b_z       (b_z),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    string       name;
    logic [31:0] ax, ay, az, bx, by, bz;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ops(input logic [31:0] ax, input logic [31:0] ay, input logic [31:0] az,
                           input logic [31:0] bx, input logic [31:0] by, input logic [31:0] bz);
    a_x = ax; a_y = ay; a_z = az;
    b_x = bx; b_y = by; b_z = bz;
  endtask

  // Waits (bounded) for out_valid after an accepting edge; returns edge count.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    check({v.name, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
    drive_ops(v.ax, v.ay, v.az, v.bx, v.by, v.bz);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({v.name, " in_ready after accept"}, {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    check({v.name, " latency"}, lat, 32'd4);
    check({v.name, " result"}, result, v.res);
    check({v.name, " overflow"}, {31'd0, overflow}, {31'd0, v.ovf});
    @(posedge clk); #1;
    check({v.name, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    check({v.name, " overflow clear"}, {31'd0, overflow}, 32'd0);
    check({v.name, " in_ready back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic [31:0] held_res;
    logic        held_ovf;

    vecs[0]  = '{"unit_x",     32'h00010000, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0, 32'h00010000, 1'b0};
    vecs[1]  = '{"ints_123",   32'h00010000, 32'h00020000, 32'h00030000,
                               32'h00040000, 32'h00050000, 32'h00060000, 32'h00200000, 1'b0};
    vecs[2]  = '{"sat_pos",    32'h40000000, 32'h0, 32'h0, 32'h00040000, 32'h0, 32'h0, 32'h7FFFFFFF, 1'b1};
    vecs[3]  = '{"sat_neg",    32'hC0000000, 32'h0, 32'h0, 32'h00040000, 32'h0, 32'h0, 32'h80000000, 1'b1};
    vecs[4]  = '{"wide_cancel",32'h40000000, 32'h40000000, 32'h0,
                               32'h00040000, 32'hFFFC0000, 32'h0, 32'h00000000, 1'b0};
    vecs[5]  = '{"fractions",  32'hFFFF8000, 32'h00000001, 32'hFFFFFFFF,
                               32'h00008000, 32'h00000001, 32'h00000001, 32'hFFFFBFFF, 1'b0};
    vecs[6]  = '{"neg_neg",    32'hFFFE0000, 32'h0, 32'h0, 32'hFFFD0000, 32'h0, 32'h0, 32'h00060000, 1'b0};
    vecs[7]  = '{"max_exact",  32'h7FFFFFFF, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0, 32'h7FFFFFFF, 1'b0};
    vecs[8]  = '{"max_plus1",  32'h7FFFFFFF, 32'h00000001, 32'h0,
                               32'h00010000, 32'h00010000, 32'h0, 32'h7FFFFFFF, 1'b1};
    vecs[9]  = '{"min_exact",  32'h80000000, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0, 32'h80000000, 1'b0};
    vecs[10] = '{"min_minus1", 32'h80000000, 32'hFFFFFFFF, 32'h0,
                               32'h00010000, 32'h00010000, 32'h0, 32'h80000000, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_ops(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result",    result, 32'd0);
    check("reset overflow",  {31'd0, overflow}, 32'd0);
    check("reset in_ready",  {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: a saturated result is held while new operands are offered.
    @(negedge clk);
    drive_ops(32'h40000000, 32'h0, 32'h0, 32'h00040000, 32'h0, 32'h0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("bp latency", lat, 32'd4);
    held_res = result;
    held_ovf = overflow;
    check("bp result", held_res, 32'h7FFFFFFF);
    check("bp overflow", {31'd0, held_ovf}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive_ops(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 32'h00050000, 32'h00060000);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp hold result",    result, 32'h7FFFFFFF);
      check("bp hold overflow",  {31'd0, overflow}, 32'd1);
      check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
      check("bp hold in_ready",  {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release in_ready",  {31'd0, in_ready}, 32'd1);
    check("bp release overflow",  {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp second accepted", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    check("bp second latency", lat, 32'd4);
    check("bp second result", result, 32'h00200000);
    check("bp second overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    check("bp second drop", {31'd0, out_valid}, 32'd0);

    // Reset after E2 aborts the transaction with no output.
    @(negedge clk);
    drive_ops(32'h40000000, 32'h0, 32'h0, 32'h00040000, 32'h0, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort result",    result, 32'd0);
    check("abort in_ready",  {31'd0, in_ready}, 32'd1);
    check("abort overflow",  {31'd0, overflow}, 32'd0);
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("abort no output", lat, 32'd0);
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
